// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU.
// Opcode encoding and FSM state enum.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_XOR  = 4'd1,
        OP_OR   = 4'd2,
        OP_AND  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SLT  = 4'd7,
        OP_ADD  = 4'd8,
        OP_ADDU = 4'd9,
        OP_SUB  = 4'd10,
        OP_SUBU = 4'd11,
        OP_MULT = 4'd12,
        OP_DIV  = 4'd13,
        OP_SRA  = 4'd14
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider.
// One bit per cycle, XLEN cycles; done flags the final step.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    logic            busy_q;
    logic [SHW-1:0]  cnt_q;
    logic            div_q;
    logic            negq_q;
    logic            negr_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] dvs_q;

    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     msum;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   hi_d;
    logic [XLEN-1:0]   lo_d;
    logic [2*XLEN-1:0] prod;

    assign a_mag = (is_signed && a[XLEN-1]) ? -a : a;
    assign b_mag = (is_signed && b[XLEN-1]) ? -b : b;
    assign done  = busy_q && (cnt_q == LAST);

    // One iteration step plus final sign fix-up of the step result.
    always_comb begin
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        trial = {hi_q, lo_q[XLEN-1]} - {1'b0, dvs_q};
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (div_q) begin
            if (!trial[XLEN]) begin
                hi_d = trial[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = msum[XLEN:1];
            lo_d = {msum[0], lo_q[XLEN-1:1]};
        end
        prod = {hi_d, lo_d};
        if (negq_q && !div_q) begin
            prod = -prod;
        end
        if (div_q) begin
            lo = negq_q ? -lo_d : lo_d;
            hi = negr_q ? -hi_d : hi_d;
        end else begin
            lo = prod[XLEN-1:0];
            hi = prod[2*XLEN-1:XLEN];
        end
    end

    // Operand load on start, then iterate until the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            div_q  <= is_div;
            negq_q <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
            negr_q <= is_signed && a[XLEN-1];
            hi_q   <= '0;
            lo_q   <= a_mag;
            dvs_q  <= b_mag;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + SHW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops,
// flags, and the iterative mul/div sub-unit.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] hi,
    output logic            zero,
    output logic            negative,
    output logic            overflow,
    output logic            div_by_zero
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t      state_q, state_d;
    alu_op_t         op_q, op_e;
    logic [XLEN-1:0] a_q, b_q;
    logic            sgn_q;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;
    logic            cap;

    logic            accept;
    logic            is_md;
    logic            md_done;
    logic [XLEN-1:0] md_lo, md_hi;
    logic [XLEN-1:0] alu_res;
    logic            alu_ovf;
    logic [XLEN-1:0] add_s, sub_s;
    logic [SHW-1:0]  sh;

    assign op_e     = alu_op_t'(op);
    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign is_md    = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign sh       = b[SHW-1:0];
    assign add_s    = a + b;
    assign sub_s    = a - b;

    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign negative    = neg_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

    alu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_md),
        .is_div    (op_e == OP_DIV),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .lo        (md_lo),
        .hi        (md_hi)
    );

    // Single-cycle operations evaluated on the live request.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_e)
            OP_NOP:  alu_res = a;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                ($signed(a) < $signed(b))};
            OP_ADD: begin
                alu_res = add_s;
                alu_ovf = (a[XLEN-1] == b[XLEN-1]) &&
                          (add_s[XLEN-1] != a[XLEN-1]);
            end
            OP_ADDU: alu_res = add_s;
            OP_SUB: begin
                alu_res = sub_s;
                alu_ovf = (a[XLEN-1] != b[XLEN-1]) &&
                          (sub_s[XLEN-1] != a[XLEN-1]);
            end
            OP_SUBU: alu_res = sub_s;
            default: alu_res = '0;
        endcase
    end

    // FSM next state and result capture.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        cap      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_md) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        cap      = 1'b1;
                        result_d = alu_res;
                        hi_d     = '0;
                        ovf_d    = alu_ovf;
                        dbz_d    = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    cap      = 1'b1;
                    result_d = md_lo;
                    hi_d     = md_hi;
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    if (op_q == OP_DIV) begin
                        if (b_q == '0) begin
                            result_d = '1;
                            hi_d     = a_q;
                            dbz_d    = 1'b1;
                        end else begin
                            ovf_d = sgn_q && (a_q == MIN_NEG) &&
                                    (b_q == '1);
                        end
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cap) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[XLEN-1];
        end
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            if (accept) begin
                op_q  <= op_e;
                a_q   <= a;
                b_q   <= b;
                sgn_q <= is_signed;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (XLEN=32).
// Vector table plus hold and mid-operation reset sequences.
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t v[24];

    multicycle_alu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic s,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic rdy, output int lat);
        @(negedge clk);
        op = o;
        is_signed = s;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [3:0] fl;

        v[0]  = '{4'd8,  0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 4'b0110, 1};
        v[1]  = '{4'd9,  0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 4'b0100, 1};
        v[2]  = '{4'd10, 0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 4'b0010, 1};
        v[3]  = '{4'd11, 0, 32'h5, 32'h5, 32'h0, 0, 4'b1000, 1};
        v[4]  = '{4'd1,  0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 4'b0000, 1};
        v[5]  = '{4'd2,  0, 32'h12340000, 32'h00005678, 32'h12345678, 0, 4'b0000, 1};
        v[6]  = '{4'd3,  0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 4'b0100, 1};
        v[7]  = '{4'd4,  0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 4'b0100, 1};
        v[8]  = '{4'd5,  0, 32'h1, 32'h24, 32'h10, 0, 4'b0000, 1};
        v[9]  = '{4'd6,  0, 32'h80000000, 32'h1F, 32'h1, 0, 4'b0000, 1};
        v[10] = '{4'd14, 0, 32'h80000000, 32'h21, 32'hC0000000, 0, 4'b0100, 1};
        v[11] = '{4'd7,  0, 32'h80000000, 32'h1, 32'h1, 0, 4'b0000, 1};
        v[12] = '{4'd7,  0, 32'h1, 32'h80000000, 32'h0, 0, 4'b1000, 1};
        v[13] = '{4'd0,  0, 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 0, 4'b0100, 1};
        v[14] = '{4'd15, 0, 32'h1, 32'h2, 32'h0, 0, 4'b1000, 1};
        v[15] = '{4'd12, 1, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b0100, 33};
        v[16] = '{4'd12, 0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 4'b0100, 33};
        v[17] = '{4'd13, 1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0100, 33};
        v[18] = '{4'd13, 0, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h5, 4'b0101, 33};
        v[19] = '{4'd13, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 4'b0110, 33};
        v[20] = '{4'd13, 0, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 33};
        v[21] = '{4'd12, 1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h6, 0, 4'b0000, 33};
        v[22] = '{4'd13, 1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 4'b0100, 33};
        v[23] = '{4'd8,  0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 4'b1000, 1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 4'd0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        fl = {zero, negative, overflow, div_by_zero};
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst flags", 64'(fl), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 24; i++) begin
            issue(v[i].op, v[i].sg, v[i].a, v[i].b, 1'b1, lat);
            fl = {zero, negative, overflow, div_by_zero};
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(v[i].lat));
            chk($sformatf("v%0d result", i), 64'(result), 64'(v[i].res));
            chk($sformatf("v%0d hi", i), 64'(hi), 64'(v[i].hi));
            chk($sformatf("v%0d flags", i), 64'(fl), 64'(v[i].fl));
        end

        issue(4'd8, 0, 32'd3, 32'd4, 1'b0, lat);
        chk("hold latency", 64'(lat), 64'd1);
        op = 4'd10;
        a = 32'd100;
        b = 32'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d result", k), 64'(result), 64'd7);
            chk($sformatf("hold%0d ready", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", 64'(in_ready), 64'd1);
        chk("release out_valid", 64'(out_valid), 64'd0);
        chk("release result", 64'(result), 64'd7);

        @(negedge clk);
        op = 4'd13;
        is_signed = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort no valid", 64'(seen), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort hi", 64'(hi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (even, >=8).
REQ-002 SHALL have derived constant SHW = $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept request.
REQ-007 op  input  4  operation code, same encoding as existing ALU: NOP=0 XOR=1 OR=2 AND=3 NOR=4 SLL=5 SRL=6 SLT=7 ADD=8 ADDU=9 SUB=10 SUBU=11 MULT=12 DIV=13 SRA=14; 15 reserved.
REQ-008 is_signed  input  1  signed mode for MULT/DIV.
REQ-009 a, b  input  XLEN  operands.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  low result (product low / quotient / ALU out).
REQ-013 hi  output  XLEN  product high / remainder; 0 for single-cycle ops.
REQ-014 zero, negative, overflow, div_by_zero  output  1 each  status flags.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-016 Request accepted when in_valid && in_ready; operands and op SHALL be registered at acceptance.
REQ-017 Single-cycle ops (all except MULT/DIV) SHALL go IDLE->DONE; out_valid asserted the cycle after acceptance.
REQ-018 MULT/DIV SHALL go IDLE->BUSY, iterate exactly XLEN cycles (one bit per cycle), then DONE; out_valid asserted XLEN+1 cycles after acceptance.
REQ-019 In DONE, result/hi/flags SHALL be held stable until out_valid && out_ready; then -> IDLE; no new request accepted in that same cycle.
REQ-020 Shifts SHALL use only b[SHW-1:0]; SRA SHALL be arithmetic (sign-filled).
REQ-021 SLT SHALL be a true signed compare (a<b signed) yielding 1 or 0, no overflow artefacts.
REQ-022 ADD/SUB SHALL set overflow on signed overflow; ADDU/SUBU SHALL never set overflow; results wrap modulo 2^XLEN.
REQ-023 MULT SHALL produce 2*XLEN-bit product {hi,result}; signed mode via magnitudes then conditional negate.
REQ-024 DIV SHALL be restoring division; result=quotient, hi=remainder; signed mode: quotient truncates toward zero, remainder takes sign of a.
REQ-025 DIV with b==0 SHALL give result all-ones, hi=a, div_by_zero=1, same latency.
REQ-026 Signed DIV of most-negative by -1 SHALL give result=most-negative, hi=0, overflow=1.
REQ-027 NOP SHALL pass a; reserved op 15 SHALL give result 0, hi 0.
REQ-028 zero = (result==0); negative = result[XLEN-1]; both registered with result.

Reset
REQ-029 On rst_n low, state SHALL be IDLE, out_valid=0, result=0, hi=0, all flags 0, iteration counter 0; in_ready=1 after release.
REQ-030 Reset mid-BUSY or in DONE SHALL abort the operation; no out_valid after release until a new request.

Structure
REQ-031 Shared package alu_pkg SHALL hold alu_op_t enum (codes above) and the FSM state enum.
REQ-032 Iterative datapath SHALL be sub-module alu_muldiv (start, is_div, is_signed, a, b -> done, lo, hi), counter internal.
REQ-033 Top level SHALL hold FSM, handshake, single-cycle ops and flag logic.

Verification (XLEN=32)
REQ-034 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, negative=1, out_valid 1 cycle after accept; ADDU same -> overflow=0.
REQ-035 MULT signed a=-3 b=7 -> {hi,result}=0xFFFFFFFF_FFFFFFEB, out_valid 33 cycles after accept; unsigned 0xFFFFFFFF*2 -> hi=1, result=0xFFFFFFFE.
REQ-036 DIV signed a=-7 b=2 -> result 0xFFFFFFFD, hi 0xFFFFFFFF; DIV b=0 a=5 -> result 0xFFFFFFFF, hi 5, div_by_zero=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.
REQ-038 Assert rst_n low at BUSY cycle 10 of a DIV -> out_valid=0, in_ready=1 after release, no stale result.
REQ-039 SRA a=0x80000000 b=0x21 -> result 0xC0000000 (shift 1); SLT a=0x80000000 b=1 -> 1.
